// File: rtl/wb_pkg.sv
// Shared types and widths for the write-back arbiter and its per-channel FIFOs.
package wb_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   typedef struct packed {
      logic [ADDR_W-1:0] index;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   typedef enum logic {
      TOKEN_A = 1'b0,
      TOKEN_B = 1'b1
   } token_e;

   function automatic logic sameIndex(input wb_entry_t x, input wb_entry_t y);
      return (x.index == y.index);
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Single-clock FIFO of write-back entries with occupancy, full and empty.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                       clock,
   input  logic                       clear_n,
   input  logic                       push,
   input  wb_entry_t                  pushEntry,
   input  logic                       pop,
   output wb_entry_t                  headEntry,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);

   wb_entry_t         mem_r [DEPTH];
   logic [PW-1:0]     wrPtr_r;
   logic [PW-1:0]     rdPtr_r;
   logic [CW-1:0]     count_r;
   logic              doPush_s;
   logic              doPop_s;

   assign full      = (count_r == CW'(DEPTH));
   assign empty     = (count_r == CW'(0));
   assign count     = count_r;
   assign headEntry = mem_r[rdPtr_r];
   // a full FIFO refuses a push even when the head leaves on the same edge
   assign doPush_s  = push && !full;
   assign doPop_s   = pop && !empty;

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clock) begin
      if (doPush_s) begin
         mem_r[wrPtr_r] <= pushEntry;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         wrPtr_r <= PW'(0);
         rdPtr_r <= PW'(0);
         count_r <= CW'(0);
      end else begin
         if (doPush_s) begin
            wrPtr_r <= wrPtr_r + PW'(1);
         end
         if (doPop_s) begin
            rdPtr_r <= rdPtr_r + PW'(1);
         end
         case ({doPush_s, doPop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Write-back stage: buffers ALU (A) and load (B) results and drives both
// register-file write ports, never presenting the same index on both.
module writeback_arbiter
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                       clock,
   input  logic                       clear_n,
   input  logic                       a_valid,
   output logic                       a_ready,
   input  logic [ADDR_W-1:0]          a_index,
   input  logic [DATA_W-1:0]          a_data,
   input  logic                       b_valid,
   output logic                       b_ready,
   input  logic [ADDR_W-1:0]          b_index,
   input  logic [DATA_W-1:0]          b_data,
   output logic                       write1,
   output logic [ADDR_W-1:0]          writeIndex1,
   output logic [DATA_W-1:0]          writeData1,
   output logic                       write2,
   output logic [ADDR_W-1:0]          writeIndex2,
   output logic [DATA_W-1:0]          writeData2,
   output logic [$clog2(DEPTH+1)-1:0] a_count,
   output logic [$clog2(DEPTH+1)-1:0] b_count,
   output logic                       busy
);

   wb_entry_t         entryA_s;
   wb_entry_t         entryB_s;
   wb_entry_t         headA_s;
   wb_entry_t         headB_s;
   logic              pushA_s;
   logic              pushB_s;
   logic              popA_s;
   logic              popB_s;
   logic              conflict_s;
   logic              fullA_s;
   logic              fullB_s;
   logic              emptyA_s;
   logic              emptyB_s;
   token_e            token_r;
   logic              write1_r;
   logic              write2_r;
   logic [ADDR_W-1:0] index1_r;
   logic [ADDR_W-1:0] index2_r;
   logic [DATA_W-1:0] data1_r;
   logic [DATA_W-1:0] data2_r;

   assign entryA_s = {a_index, a_data};
   assign entryB_s = {b_index, b_data};
   // ready is held low for the whole time the reset is asserted
   assign a_ready  = clear_n && !fullA_s;
   assign b_ready  = clear_n && !fullB_s;
   assign pushA_s  = a_valid && a_ready;
   assign pushB_s  = b_valid && b_ready;

   wb_fifo #(.DEPTH(DEPTH)) fifoA (
      .clock     (clock),
      .clear_n   (clear_n),
      .push      (pushA_s),
      .pushEntry (entryA_s),
      .pop       (popA_s),
      .headEntry (headA_s),
      .count     (a_count),
      .full      (fullA_s),
      .empty     (emptyA_s)
   );

   wb_fifo #(.DEPTH(DEPTH)) fifoB (
      .clock     (clock),
      .clear_n   (clear_n),
      .push      (pushB_s),
      .pushEntry (entryB_s),
      .pop       (popB_s),
      .headEntry (headB_s),
      .count     (b_count),
      .full      (fullB_s),
      .empty     (emptyB_s)
   );

   // Issue decision from the heads as they stand before this edge's pushes.
   always_comb begin
      popA_s     = 1'b0;
      popB_s     = 1'b0;
      conflict_s = 1'b0;
      case ({!emptyA_s, !emptyB_s})
         2'b10: popA_s = 1'b1;
         2'b01: popB_s = 1'b1;
         2'b11: begin
            if (sameIndex(headA_s, headB_s)) begin
               conflict_s = 1'b1;
               if (token_r == TOKEN_A) begin
                  popA_s = 1'b1;
               end else begin
                  popB_s = 1'b1;
               end
            end else begin
               popA_s = 1'b1;
               popB_s = 1'b1;
            end
         end
         default: begin
            popA_s = 1'b0;
            popB_s = 1'b0;
         end
      endcase
   end

   // Registered write ports and the fairness token; a conflict winner always uses port 1.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         write1_r <= 1'b0;
         index1_r <= ADDR_W'(0);
         data1_r  <= DATA_W'(0);
         write2_r <= 1'b0;
         index2_r <= ADDR_W'(0);
         data2_r  <= DATA_W'(0);
         token_r  <= TOKEN_A;
      end else begin
         if (popA_s) begin
            write1_r <= 1'b1;
            index1_r <= headA_s.index;
            data1_r  <= headA_s.data;
         end else if (popB_s && conflict_s) begin
            write1_r <= 1'b1;
            index1_r <= headB_s.index;
            data1_r  <= headB_s.data;
         end else begin
            write1_r <= 1'b0;
            index1_r <= ADDR_W'(0);
            data1_r  <= DATA_W'(0);
         end
         if (popB_s && !conflict_s) begin
            write2_r <= 1'b1;
            index2_r <= headB_s.index;
            data2_r  <= headB_s.data;
         end else begin
            write2_r <= 1'b0;
            index2_r <= ADDR_W'(0);
            data2_r  <= DATA_W'(0);
         end
         if (conflict_s) begin
            token_r <= (token_r == TOKEN_A) ? TOKEN_B : TOKEN_A;
         end else begin
            token_r <= token_r;
         end
      end
   end

   assign write1      = write1_r;
   assign writeIndex1 = index1_r;
   assign writeData1  = data1_r;
   assign write2      = write2_r;
   assign writeIndex2 = index2_r;
   assign writeData2  = data2_r;
   assign busy        = !emptyA_s || !emptyB_s || write1_r || write2_r;

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Write-back stage that sits directly upstream of the 32x32 dual-write-port register file and drives its two write ports.
- Accepts results from two producers over valid/ready channels: channel A (ALU) and channel B (load unit).
- Buffers each channel in its own small FIFO.
- Issues up to two register writes per cycle and never presents both write ports with the same index.
- Serializes same-index writes with fair, starvation-free priority.

Parameters:
- DEPTH, 4, entries per channel FIFO; power of two, minimum 2.
- DATA_W, 32, result data width.
- ADDR_W, 5, register index width.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- clear_n  input  1  asynchronous active-low reset.
- a_valid  input  1  channel A result valid.
- a_ready  output  1  channel A can accept.
- a_index  input  ADDR_W  channel A destination register.
- a_data  input  DATA_W  channel A result.
- b_valid  input  1  channel B result valid.
- b_ready  output  1  channel B can accept.
- b_index  input  ADDR_W  channel B destination register.
- b_data  input  DATA_W  channel B result.
- write1  output  1  register file port 1 write enable.
- writeIndex1  output  ADDR_W  port 1 index.
- writeData1  output  DATA_W  port 1 data.
- write2  output  1  register file port 2 write enable.
- writeIndex2  output  ADDR_W  port 2 index.
- writeData2  output  DATA_W  port 2 data.
- a_count  output  $clog2(DEPTH+1)  channel A FIFO occupancy.
- b_count  output  $clog2(DEPTH+1)  channel B FIFO occupancy.
- busy  output  1  any FIFO non-empty or any write enable asserted.

Behaviour:
- Reset (clear_n low, asynchronous):
  - FIFOs emptied; counts 0.
  - write1, write2, busy = 0; index and data outputs = 0.
  - Priority token = A.
  - a_ready and b_ready = 1 once reset releases; they are 0 while clear_n is low.
- Accept:
  - Push on rising edge when x_valid && x_ready.
  - x_ready = (x_count != DEPTH). No same-cycle push-through when full, even if a pop occurs in that cycle.
- All write-port outputs are registered on the rising edge. They are held stable through the following falling edge, where the register file samples them.
- Issue decision each rising edge, using the FIFO heads as they stood before that edge's pushes:
  - No heads valid: write1 = write2 = 0.
  - A head only: pop A; port 1 = A entry; write2 = 0.
  - B head only: pop B; port 2 = B entry; write1 = 0.
  - Both heads, indices differ: pop both; A to port 1, B to port 2.
  - Both heads, indices equal (conflict):
    - Pop only the token holder and drive its entry on port 1; write2 = 0.
    - Token flips to the other channel.
    - The loser issues no earlier than the next edge.
  - The token changes only on a conflict.
- Latency:
  - An entry pushed at edge N into an empty FIFO with no conflict drives its write port after edge N+1.
  - The register file writes it on the falling edge that follows edge N+1.
- Ordering:
  - Program order is preserved within each channel.
  - Across channels, order is defined only on conflict, by the token.
  - A conflict loser waits at most one extra cycle per conflict.
- Counts: x_count updates as +1 on push, -1 on pop, unchanged on simultaneous push and pop.
- Pointers: FIFO pointers wrap modulo DEPTH.
- Reset mid-operation: pending entries are discarded and write enables drop immediately (asynchronous), with no partial write to the register file.

Decomposition:
- Shared package wb_pkg:
  - ADDR_W and DATA_W constants.
  - wb_entry_t struct {index, data}.
- Sub-module wb_fifo: parameterized DEPTH single-clock FIFO with count, full and empty. It is instantiated once per channel.
- The arbiter top holds the token, the conflict compare and the output registers.

Test Plan:
- Reset then idle:
  - Stimulus: clear_n low then high, no valids.
  - Response: write1 = write2 = 0, busy = 0, a_ready = b_ready = 1, counts = 0.
- Dual issue:
  - Stimulus: one edge with A (idx 3, 243) and B (idx 7, 71).
  - Response: the next edge drives write1 (3, 243) and write2 (7, 71) together; readback from the register file gives those values.
- Conflict and fairness:
  - Stimulus: A (idx 2, 741) and B (idx 2, 12) pushed on the same edge.
  - Response:
    - Cycle 1: write1 (2, 741), write2 = 0.
    - Cycle 2: write1 = 0, write2 (2, 12); final register 2 = 12.
    - Repeating the pair: B issues first (write1 (2, 12)), then A.
- Full / backpressure:
  - Stimulus: hold b_valid with distinct indices while B keeps conflicting with a stream of A entries to the same indices.
  - Response: b_count reaches 4; b_ready = 0; no push is lost or duplicated. Every pushed value is written exactly once, in per-channel order.
- Wrap-around: push 10 sequential A entries (idx i, data 100+i), back-to-back, with no stalls → they are written in order with no gaps, and a_count never exceeds 2.
- Reset mid-operation:
  - Stimulus: drive clear_n low with both FIFOs holding 3 entries.
  - Response: write enables drop immediately, counts = 0, and no stale write appears after release.
